// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// valid/ready holding register with framing-error and overrun pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] timer;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    // Idle-high synchroniser so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
            data      <= 8'd0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        timer <= '0;
                    end
                end

                // Half a bit into the start bit: still low means a real frame.
                START: begin
                    if (timer == HALF_TC) begin
                        timer <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                DATA: begin
                    if (timer == BIT_TC) begin
                        timer     <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                // A completing byte overrides a same-cycle clear of valid.
                STOP: begin
                    if (timer == BIT_TC) begin
                        timer <= '0;
                        state <= IDLE;
                        if (rx_s) begin
                            if (!valid || ready) begin
                                data  <= shift_reg;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected bytes are queued as frames are sent
// and compared when the receiver hands a byte over.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    int         checks;
    int         failures;
    int         cyc;
    int         fe_cnt;
    int         ov_cnt;
    int         last_vcyc;
    logic [7:0] exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) begin
                last_vcyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {24'd0, data}, 32'hDEAD);
                end else begin
                    chk("rx_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err && overrun) chk("fe_ov_exclusive", 32'd1, 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    initial begin
        int start_cyc;
        int lat;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        fe_cnt    = 0;
        ov_cnt    = 0;
        last_vcyc = 0;
        rx        = 1'b1;
        ready     = 1'b1;
        rst_n     = 1'b0;
        tick(3);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        // 1: single frame, latency from the start edge
        exp_q.push_back(8'hA5);
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        tick(4);
        lat = last_vcyc - start_cyc;
        chk("t1_latency", {31'd0, (lat >= 152 && lat <= 156)}, 32'd1);
        chk("t1_ferr", fe_cnt, 0);
        chk("t1_ovr", ov_cnt, 0);

        // 2: short glitch rejected, then a good frame
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        chk("t2_no_valid", {31'd0, valid}, 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        tick(4);
        chk("t2_ferr", fe_cnt, 0);

        // 3: bad stop bit, then recovery
        send_frame(8'h81, 1'b0);
        tick(30);
        chk("t3_ferr_pulse", fe_cnt, 1);
        chk("t3_no_valid", {31'd0, valid}, 32'd0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        tick(4);
        chk("t3_ferr_after", fe_cnt, 1);

        // 4: overrun while the holding register is full
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        tick(4);
        chk("t4_valid", {31'd0, valid}, 32'd1);
        chk("t4_data", {24'd0, data}, 32'h11);
        send_frame(8'h22, 1'b1);
        tick(4);
        chk("t4_ovr_pulse", ov_cnt, 1);
        chk("t4_data_kept", {24'd0, data}, 32'h11);
        chk("t4_valid_held", {31'd0, valid}, 32'd1);
        exp_q.push_back(8'h11);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        chk("t4_valid_clr", {31'd0, valid}, 32'd0);
        ready = 1'b1;
        tick(4);

        // 5: back-to-back frames with no idle gap
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(20);
        chk("t5_drained", exp_q.size(), 0);
        chk("t5_ovr", ov_cnt, 1);

        // 6: reset in the middle of data bit 4
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'h5A >> i);
            tick(CPB);
        end
        rx = 1'b1;
        tick(CPB / 2);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", {31'd0, valid}, 32'd0);
        chk("t6_data", {24'd0, data}, 32'd0);
        chk("t6_ferr", {31'd0, frame_err}, 32'd0);
        chk("t6_ovr", {31'd0, overrun}, 32'd0);
        tick(4);
        rst_n = 1'b1;
        tick(10);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        tick(20);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_ferr", fe_cnt, 1);
        chk("final_ovr", ov_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
